// File: rtl/rps_pkg.sv
// Shared encodings for the rock-paper-scissors match controller:
// move codes, FSM states and the opponent LFSR feedback taps.
package rps_pkg;

  localparam int unsigned MOVE_W = 2;
  localparam int unsigned LFSR_W = 8;

  typedef logic [MOVE_W-1:0] move_t;

  localparam move_t MOVE_ROCK     = 2'd0;
  localparam move_t MOVE_PAPER    = 2'd1;
  localparam move_t MOVE_SCISSORS = 2'd2;

  // Feedback from bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    ST_SELECT,
    ST_LOCK,
    ST_RESOLVE,
    ST_SHOW,
    ST_MATCH_END
  } state_e;

  // Code 3 is not a legal move; treat it as rock
  function automatic move_t fold_move(input logic [MOVE_W-1:0] m);
    return (m == 2'd3) ? MOVE_ROCK : move_t'(m);
  endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational round judge: (player - opp) mod 3 -> 1 win, 2 lose, 0 tie.
module rps_judge
  import rps_pkg::*;
(
  input  logic [1:0] player_move,
  input  logic [1:0] opp_move,
  output logic       win_c,
  output logic       lose_c,
  output logic       tie_c
);

  logic [2:0] diff;

  always_comb begin
    diff   = 3'(player_move) + 3'd3 - 3'(opp_move);
    win_c  = 1'b0;
    lose_c = 1'b0;
    tie_c  = 1'b0;
    case (diff)
      3'd1, 3'd4: win_c  = 1'b1;
      3'd2, 3'd5: lose_c = 1'b1;
      default:    tie_c  = 1'b1;
    endcase
  end

endmodule

// File: rtl/rps_match_controller.sv
// Rock-paper-scissors match controller: locks a move on a stop edge, judges it
// against an LFSR or external opponent, keeps score and ends the match.
module rps_match_controller
  import rps_pkg::*;
#(
  parameter int unsigned ROUNDS_TO_WIN = 2,
  parameter int unsigned SCORE_W       = 4,
  parameter int unsigned SHOW_CYCLES   = 8,
  parameter int unsigned EXT_OPP       = 0,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               rock_button,
  input  logic               paper_button,
  input  logic               scissors_button,
  input  logic               stop_signal,
  input  logic [1:0]         opp_choice,
  output logic               win_led,
  output logic               lose_led,
  output logic               tie_led,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] cpu_score,
  output logic [1:0]         cpu_choice,
  output logic               round_done,
  output logic               match_over
);

  localparam int unsigned CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(ROUNDS_TO_WIN);

  state_e              state_q, state_d;
  logic                stop_q, stop_rst_q;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  move_t               player_move_q, player_move_d;
  move_t               cpu_choice_q, cpu_choice_d;
  logic                win_q, win_d, lose_q, lose_d, tie_q, tie_d;
  logic [SCORE_W-1:0]  player_score_q, player_score_d;
  logic [SCORE_W-1:0]  cpu_score_q, cpu_score_d;
  logic                round_done_q, round_done_d;
  logic                match_over_q, match_over_d;
  logic [CNT_W-1:0]    show_cnt_q, show_cnt_d;

  logic                stop_edge_c;
  logic                one_btn_c;
  move_t               btn_move_c;
  logic                judge_win_c, judge_lose_c, judge_tie_c;

  rps_judge u_judge (
    .player_move (player_move_q),
    .opp_move    (cpu_choice_q),
    .win_c       (judge_win_c),
    .lose_c      (judge_lose_c),
    .tie_c       (judge_tie_c)
  );

  // stop_rst_q masks a stop level that was already high when reset released
  assign stop_edge_c = stop_signal & ~stop_q & ~stop_rst_q;

  always_comb begin
    one_btn_c  = 1'b0;
    btn_move_c = MOVE_ROCK;
    case ({rock_button, paper_button, scissors_button})
      3'b100:  begin one_btn_c = 1'b1; btn_move_c = MOVE_ROCK;     end
      3'b010:  begin one_btn_c = 1'b1; btn_move_c = MOVE_PAPER;    end
      3'b001:  begin one_btn_c = 1'b1; btn_move_c = MOVE_SCISSORS; end
      default: begin one_btn_c = 1'b0; btn_move_c = MOVE_ROCK;     end
    endcase
  end

  always_comb begin
    state_d        = state_q;
    lfsr_d         = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    player_move_d  = player_move_q;
    cpu_choice_d   = cpu_choice_q;
    win_d          = win_q;
    lose_d         = lose_q;
    tie_d          = tie_q;
    player_score_d = player_score_q;
    cpu_score_d    = cpu_score_q;
    round_done_d   = 1'b0;
    show_cnt_d     = show_cnt_q;

    case (state_q)
      ST_SELECT: begin
        // The move that qualified the stop edge is the one played
        if (stop_edge_c && one_btn_c) begin
          player_move_d = btn_move_c;
          state_d       = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (EXT_OPP != 0) cpu_choice_d = fold_move(opp_choice);
        else              cpu_choice_d = fold_move(lfsr_q[1:0]);
        state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        win_d        = judge_win_c;
        lose_d       = judge_lose_c;
        tie_d        = judge_tie_c;
        round_done_d = 1'b1;
        if (judge_win_c && (player_score_q < WIN_SCORE))
          player_score_d = player_score_q + SCORE_W'(1);
        if (judge_lose_c && (cpu_score_q < WIN_SCORE))
          cpu_score_d = cpu_score_q + SCORE_W'(1);
        show_cnt_d = '0;
        state_d    = ST_SHOW;
      end
      ST_SHOW: begin
        if (show_cnt_q == SHOW_LAST) begin
          if ((player_score_q == WIN_SCORE) || (cpu_score_q == WIN_SCORE))
            state_d = ST_MATCH_END;
          else
            state_d = ST_SELECT;
        end else begin
          show_cnt_d = show_cnt_q + CNT_W'(1);
        end
      end
      ST_MATCH_END: begin
        if (stop_edge_c) begin
          player_score_d = '0;
          cpu_score_d    = '0;
          win_d          = 1'b0;
          lose_d         = 1'b0;
          tie_d          = 1'b0;
          state_d        = ST_SELECT;
        end
      end
      default: state_d = ST_SELECT;
    endcase

    match_over_d = (state_d == ST_MATCH_END);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= ST_SELECT;
      stop_q         <= 1'b0;
      stop_rst_q     <= stop_signal;
      lfsr_q         <= LFSR_SEED;
      player_move_q  <= MOVE_ROCK;
      cpu_choice_q   <= MOVE_ROCK;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
      tie_q          <= 1'b0;
      player_score_q <= '0;
      cpu_score_q    <= '0;
      round_done_q   <= 1'b0;
      match_over_q   <= 1'b0;
      show_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      stop_q         <= stop_signal;
      stop_rst_q     <= 1'b0;
      lfsr_q         <= lfsr_d;
      player_move_q  <= player_move_d;
      cpu_choice_q   <= cpu_choice_d;
      win_q          <= win_d;
      lose_q         <= lose_d;
      tie_q          <= tie_d;
      player_score_q <= player_score_d;
      cpu_score_q    <= cpu_score_d;
      round_done_q   <= round_done_d;
      match_over_q   <= match_over_d;
      show_cnt_q     <= show_cnt_d;
    end
  end

  assign win_led      = win_q;
  assign lose_led     = lose_q;
  assign tie_led      = tie_q;
  assign player_score = player_score_q;
  assign cpu_score    = cpu_score_q;
  assign cpu_choice   = cpu_choice_q;
  assign round_done   = round_done_q;
  assign match_over   = match_over_q;

endmodule

// File: tb/tb_rps_match_controller.sv
// Directed bench: external-opponent instance (u_a) for scoring/match/reset cases,
// LFSR-opponent instance (u_b) for a long run against a reference LFSR.
module tb_rps_match_controller;

  localparam int unsigned SC_A = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic       rock_a = 0, paper_a = 0, scis_a = 0, stop_a = 0;
  logic [1:0] opp_a = 0;
  logic       win_a, lose_a, tie_a, rd_a, mo_a;
  logic [3:0] ps_a, cs_a;
  logic [1:0] cpu_a;

  logic       rock_b = 0, paper_b = 0, scis_b = 0, stop_b = 0;
  logic       win_b, lose_b, tie_b, rd_b, mo_b;
  logic [3:0] ps_b, cs_b;
  logic [1:0] cpu_b;

  rps_match_controller #(
    .ROUNDS_TO_WIN(2), .SCORE_W(4), .SHOW_CYCLES(SC_A), .EXT_OPP(1), .LFSR_SEED(8'hA5)
  ) u_a (
    .clock(clock), .reset_n(reset_n),
    .rock_button(rock_a), .paper_button(paper_a), .scissors_button(scis_a),
    .stop_signal(stop_a), .opp_choice(opp_a),
    .win_led(win_a), .lose_led(lose_a), .tie_led(tie_a),
    .player_score(ps_a), .cpu_score(cs_a), .cpu_choice(cpu_a),
    .round_done(rd_a), .match_over(mo_a)
  );

  rps_match_controller #(
    .ROUNDS_TO_WIN(15), .SCORE_W(4), .SHOW_CYCLES(1), .EXT_OPP(0), .LFSR_SEED(8'hA5)
  ) u_b (
    .clock(clock), .reset_n(reset_n),
    .rock_button(rock_b), .paper_button(paper_b), .scissors_button(scis_b),
    .stop_signal(stop_b), .opp_choice(2'd3),
    .win_led(win_b), .lose_led(lose_b), .tie_led(tie_b),
    .player_score(ps_b), .cpu_score(cs_b), .cpu_choice(cpu_b),
    .round_done(rd_b), .match_over(mo_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt_a = 0;
  logic [7:0] lfsr_ref;
  logic [7:0] lfsr_obs;
  assign lfsr_obs = u_b.lfsr_q;

  always @(posedge clock) if (rd_a) rd_cnt_a <= rd_cnt_a + 1;

  // Independent reference LFSR for instance B
  always @(posedge clock) begin
    if (!reset_n) lfsr_ref <= 8'hA5;
    else          lfsr_ref <= {lfsr_ref[6:0], lfsr_ref[7] ^ lfsr_ref[5] ^ lfsr_ref[4] ^ lfsr_ref[3]};
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_result(input int p, input int o);
    int d;
    d = (p - o + 3) % 3;
    if (d == 1)      return 3'b100;
    else if (d == 2) return 3'b010;
    else             return 3'b001;
  endfunction

  function automatic logic [1:0] ref_fold(input logic [1:0] m);
    return (m == 2'd3) ? 2'd0 : m;
  endfunction

  // One full round on instance A, btn = {rock,paper,scissors}, res = {win,lose,tie}
  task automatic play_a(input logic [2:0] btn, input logic [1:0] opp, input logic [2:0] res,
                        input int exp_p, input int exp_c, input logic [1:0] exp_cpu,
                        input logic exp_mo);
    @(negedge clock);
    {rock_a, paper_a, scis_a} = btn;
    opp_a  = opp;
    stop_a = 1'b1;
    @(posedge clock);
    @(negedge clock);
    stop_a = 1'b0;
    @(posedge clock);
    #1 check_eq("rd_before_resolve", 32'(rd_a), 32'd0);
    @(posedge clock);
    #1;
    check_eq("leds", 32'({win_a, lose_a, tie_a}), 32'(res));
    check_eq("player_score", 32'(ps_a), 32'(exp_p));
    check_eq("cpu_score", 32'(cs_a), 32'(exp_c));
    check_eq("cpu_choice", 32'(cpu_a), 32'(exp_cpu));
    check_eq("round_done_hi", 32'(rd_a), 32'd1);
    @(posedge clock);
    #1 check_eq("round_done_lo", 32'(rd_a), 32'd0);
    repeat (SC_A - 2) @(posedge clock);
    #1 check_eq("match_over_early", 32'(mo_a), 32'd0);
    @(posedge clock);
    #1 check_eq("match_over", 32'(mo_a), 32'(exp_mo));
    {rock_a, paper_a, scis_a} = 3'b000;
  endtask

  task automatic stop_edge_a();
    @(negedge clock);
    stop_a = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    stop_a = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rd_before;
    int seen [3];
    logic [1:0] exp_cpu;
    logic [2:0] btn;
    int pm;

    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_leds", 32'({win_a, lose_a, tie_a}), 32'd0);
    check_eq("rst_scores", 32'({ps_a, cs_a}), 32'd0);
    check_eq("rst_cpu_rd_mo", 32'({cpu_a, rd_a, mo_a}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    play_a(3'b100, 2'd2, 3'b100, 1, 0, 2'd2, 1'b0);
    play_a(3'b010, 2'd2, 3'b010, 1, 1, 2'd2, 1'b0);
    play_a(3'b010, 2'd1, 3'b001, 1, 1, 2'd1, 1'b0);
    repeat (3) @(posedge clock);
    #1 check_eq("tie_hold_select", 32'({win_a, lose_a, tie_a}), 32'b001);

    // Two buttons with a stop edge: no round
    rd_before = rd_cnt_a;
    @(negedge clock);
    rock_a = 1; paper_a = 1; stop_a = 1;
    @(negedge clock);
    stop_a = 0; rock_a = 0; paper_a = 0;
    repeat (8) @(posedge clock);
    #1 check_eq("multi_btn_rounds", 32'(rd_cnt_a - rd_before), 32'd0);
    check_eq("multi_btn_leds", 32'({win_a, lose_a, tie_a}), 32'b001);

    // opp_choice 3 folds to rock; cpu reaches 2 and the match ends
    play_a(3'b001, 2'd3, 3'b010, 1, 2, 2'd0, 1'b1);

    @(negedge clock);
    rock_a = 1;
    repeat (5) @(posedge clock);
    #1;
    check_eq("end_hold_scores", 32'({ps_a, cs_a}), 32'h12);
    check_eq("end_hold_mo", 32'(mo_a), 32'd1);
    check_eq("end_hold_leds", 32'({win_a, lose_a, tie_a}), 32'b010);
    rock_a = 0;

    stop_edge_a();
    check_eq("clear_scores", 32'({ps_a, cs_a}), 32'd0);
    check_eq("clear_leds", 32'({win_a, lose_a, tie_a}), 32'd0);
    check_eq("clear_mo", 32'(mo_a), 32'd0);

    play_a(3'b100, 2'd2, 3'b100, 1, 0, 2'd2, 1'b0);
    play_a(3'b001, 2'd1, 3'b100, 2, 0, 2'd1, 1'b1);
    @(negedge clock);
    paper_a = 1;
    repeat (6) @(posedge clock);
    #1 check_eq("sat_player_score", 32'(ps_a), 32'd2);
    paper_a = 0;
    stop_edge_a();
    check_eq("clear2_scores", 32'({ps_a, cs_a}), 32'd0);

    // Stop held high for 20 cycles counts once
    rd_before = rd_cnt_a;
    @(negedge clock);
    rock_a = 1; opp_a = 2'd2; stop_a = 1;
    repeat (20) @(posedge clock);
    @(negedge clock);
    stop_a = 0; rock_a = 0;
    repeat (10) @(posedge clock);
    #1;
    check_eq("held_stop_rounds", 32'(rd_cnt_a - rd_before), 32'd1);
    check_eq("held_stop_score", 32'(ps_a), 32'd1);

    // Reset in the middle of SHOW
    @(negedge clock);
    paper_a = 1; opp_a = 2'd0; stop_a = 1;
    @(negedge clock);
    stop_a = 0;
    repeat (3) @(posedge clock);
    #1 check_eq("pre_reset_score", 32'(ps_a), 32'd2);
    @(negedge clock);
    reset_n = 0; paper_a = 0;
    @(posedge clock);
    #1;
    check_eq("show_rst_leds", 32'({win_a, lose_a, tie_a}), 32'd0);
    check_eq("show_rst_scores", 32'({ps_a, cs_a}), 32'd0);
    check_eq("show_rst_cpu_rd_mo", 32'({cpu_a, rd_a, mo_a}), 32'd0);

    // Stop high through reset release is not an edge
    @(negedge clock);
    stop_a = 1; rock_a = 1;
    @(negedge clock);
    reset_n = 1;
    rd_before = rd_cnt_a;
    repeat (10) @(posedge clock);
    #1;
    check_eq("stop_thru_rst_rounds", 32'(rd_cnt_a - rd_before), 32'd0);
    check_eq("stop_thru_rst_score", 32'(ps_a), 32'd0);
    @(negedge clock);
    stop_a = 0; rock_a = 0;

    // Long LFSR-opponent run on instance B
    @(negedge clock);
    reset_n = 0;
    @(negedge clock);
    reset_n = 1;
    seen[0] = 0; seen[1] = 0; seen[2] = 0;
    for (int r = 0; r < 1000; r++) begin
      @(negedge clock);
      if (mo_b) begin
        stop_b = 1;
        @(negedge clock);
        stop_b = 0;
        @(negedge clock);
      end
      pm = int'($urandom_range(0, 2));
      btn = 3'b100 >> pm;
      {rock_b, paper_b, scis_b} = btn;
      stop_b = 1;
      @(posedge clock);
      #1 exp_cpu = ref_fold(lfsr_ref[1:0]);
      @(negedge clock);
      stop_b = 0;
      @(posedge clock);
      #1;
      check_eq("b_cpu_choice", 32'(cpu_b), 32'(exp_cpu));
      check_eq("b_lfsr", 32'(lfsr_obs), 32'(lfsr_ref));
      if (cpu_b < 2'd3) seen[cpu_b]++;
      @(posedge clock);
      #1 check_eq("b_leds", 32'({win_b, lose_b, tie_b}), 32'(ref_result(pm, int'(exp_cpu))));
      @(posedge clock);
    end
    check_eq("b_seen_rock", 32'(seen[0] > 0), 32'd1);
    check_eq("b_seen_paper", 32'(seen[1] > 0), 32'd1);
    check_eq("b_seen_scissors", 32'(seen[2] > 0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rps_match_controller.md
RPS_MATCH_CONTROLLER -- requirements
Module: rps_match_controller

Interface
REQ-001 Parameter ROUNDS_TO_WIN, default 2, round wins that end a match (1..15).
REQ-002 Parameter SCORE_W, default 4, score counter width; SHALL satisfy 2**SCORE_W > ROUNDS_TO_WIN.
REQ-003 Parameter SHOW_CYCLES, default 8, cycles the round result is held (>=1).
REQ-004 Parameter EXT_OPP, default 0; 0 = opponent move from internal LFSR, 1 = opponent move from opp_choice input.
REQ-005 Parameter LFSR_SEED, default 8'hA5, nonzero LFSR reset value.
REQ-006 clock  in  1  single system clock, rising edge.
REQ-007 reset_n  in  1  synchronous, active-low reset.
REQ-008 rock_button / paper_button / scissors_button  in  1 each  player move, level.
REQ-009 stop_signal  in  1  lock-in request, rising-edge sensitive.
REQ-010 opp_choice  in  2  external opponent move, used only when EXT_OPP=1.
REQ-011 win_led / lose_led / tie_led  out  1 each  result of last resolved round.
REQ-012 player_score / cpu_score  out  SCORE_W  round wins this match.
REQ-013 cpu_choice  out  2  opponent move of last locked round.
REQ-014 round_done  out  1  one-cycle pulse on round resolution.
REQ-015 match_over  out  1  high while in MATCH_END.

Function
REQ-016 Move encoding SHALL be rock=0, paper=1, scissors=2; value 3 is never output.
REQ-017 FSM states SHALL be SELECT, LOCK, RESOLVE, SHOW, MATCH_END.
REQ-018 stop_signal rising edge = stop_signal high this cycle and low the previous cycle (one registered sample).
REQ-019 In SELECT, a stop edge with exactly one move button high SHALL go to LOCK next cycle; zero or multiple buttons SHALL be ignored with no state change.
REQ-020 LOCK SHALL register the player move and opponent move (LFSR-derived or opp_choice), then go to RESOLVE.
REQ-021 Opponent move from LFSR SHALL be lfsr[1:0], with 2'b11 mapped to rock; with EXT_OPP=1, opp_choice=3 SHALL be mapped to rock.
REQ-022 LFSR SHALL be 8-bit Fibonacci, shift left every cycle, new bit0 = l[7]^l[5]^l[4]^l[3], never zero.
REQ-023 RESOLVE: player wins when (player - opp) mod 3 = 1, loses when = 2, ties when = 0; exactly one LED SHALL be set; the winner's score SHALL increment; round_done SHALL pulse; then go to SHOW.
REQ-024 Outputs from a round SHALL be visible two cycles after the qualifying stop edge (LOCK, RESOLVE registered).
REQ-025 SHOW SHALL last SHOW_CYCLES cycles, then go to MATCH_END if either score equals ROUNDS_TO_WIN, else to SELECT.
REQ-026 LEDs SHALL hold their values through SELECT until the next RESOLVE overwrites them.
REQ-027 Stop edges and buttons SHALL be ignored in LOCK, RESOLVE, SHOW.
REQ-028 In MATCH_END, match_over=1 and LEDs/scores SHALL hold; a stop edge (any buttons) SHALL clear scores and LEDs and return to SELECT.
REQ-029 Scores SHALL never exceed ROUNDS_TO_WIN; no wrap.

Reset
REQ-030 With reset_n low at a rising edge: state=SELECT, scores=0, all LEDs=0, cpu_choice=0, round_done=0, match_over=0, LFSR=LFSR_SEED, edge-detect register=0.
REQ-031 Reset SHALL take priority over every event, including mid-SHOW and mid-RESOLVE; a round in flight SHALL be discarded.
REQ-032 A stop_signal held high through reset release SHALL NOT count as an edge.

Structure
REQ-033 Move encodings, FSM state encodings and the LFSR tap mask SHALL live in shared package rps_pkg.
REQ-034 The win/lose/tie comparison SHALL be sub-module rps_judge (combinational, two moves in, three result bits out), reusable by GameController.

Verification
REQ-035 EXT_OPP=1: rock, opp_choice=2, stop edge -> 2 cycles later win_led=1, player_score=1, round_done single pulse.
REQ-036 EXT_OPP=1: paper vs opp_choice=2 -> lose_led=1, cpu_score=1; paper vs 1 -> tie_led=1, scores unchanged.
REQ-037 ROUNDS_TO_WIN=2: two player wins -> match_over=1 after SHOW_CYCLES; further button presses leave scores at 2; stop edge -> scores 0, SELECT.
REQ-038 rock+paper both high with stop edge -> no round_done, state stays SELECT; stop held high 20 cycles -> only one round.
REQ-039 Assert reset_n low during SHOW -> next cycle all outputs at reset values, state SELECT.
REQ-040 EXT_OPP=0, 1000 rounds -> cpu_choice never 3, LFSR never 0, all three moves occur.
